palindrome_stream_detector: RTL

Parametrised serial palindrome detector. It checks a bit stream, one bit per accepted beat, and reports whether the last `len` received bits form a palindrome. Window length is selectable at run time, and the block supports sliding (overlapping) or block (non-overlapping) windowing. It also keeps a saturating count of palindromes found. It sits behind serial receive logic and feeds pattern-monitoring and status registers.

---
 rtl/palindrome_stream_detector.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/palindrome_stream_detector.sv
// Serial palindrome detector: checks the newest len_q accepted bits of a stream,
// with sliding or block windowing and a saturating count of palindromes found.
module palindrome_stream_detector #(
  parameter  int MAX_BITS = 16,
  parameter  int CNT_W    = 8,
  localparam int LEN_W    = $clog2(MAX_BITS + 1)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             clear_i,
  input  logic             in_valid_i,
  input  logic             in_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             mode_i,
  output logic             out_valid_o,
  output logic             out_o,
  output logic [CNT_W-1:0] count_o,
  output logic             count_sat_o
);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  localparam logic [MAX_BITS-1:0] ONES = '1;

  state_t              state_q, state_d;
  logic [MAX_BITS-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]    fill_q, fill_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                mode_q, mode_d;
  logic                out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                count_sat_q, count_sat_d;

  logic [MAX_BITS-1:0] hist_new;
  logic [MAX_BITS-1:0] hist_rev;
  logic [MAX_BITS-1:0] win_mask;
  logic [LEN_W-1:0]    rev_shift;
  logic [LEN_W-1:0]    len_clamp;
  logic [LEN_W-1:0]    fill_inc;
  logic                pal;

  assign hist_new = {hist_q[MAX_BITS-2:0], in_i};

  genvar gi;
  generate
    for (gi = 0; gi < MAX_BITS; gi++) begin : g_rev
      assign hist_rev[gi] = hist_new[MAX_BITS-1-gi];
    end
  endgenerate

  // Reversing the whole register and shifting down by MAX_BITS-len lines bit
  // len-1-k up with bit k, so a masked equality compares every mirrored pair.
  assign rev_shift = LEN_W'(MAX_BITS) - len_q;
  assign win_mask  = ~(ONES << len_q);
  assign pal       = (((hist_new ^ (hist_rev >> rev_shift)) & win_mask) == '0);

  assign len_clamp = (len_i < LEN_W'(2))        ? LEN_W'(2) :
                     (len_i > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : len_i;
  assign fill_inc  = fill_q + LEN_W'(1);

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    len_d       = len_q;
    mode_d      = mode_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    count_d     = count_q;
    count_sat_d = count_sat_q;

    // The counter trails the result pulse by one cycle.
    if (out_valid_q && out_q) begin
      if (&count_q) count_sat_d = 1'b1;
      else          count_d     = count_q + CNT_W'(1);
    end

    if (clear_i) begin
      state_d     = IDLE;
      hist_d      = '0;
      fill_d      = '0;
      len_d       = '0;
      mode_d      = 1'b0;
      out_d       = 1'b0;
      count_d     = '0;
      count_sat_d = 1'b0;
    end else if (in_valid_i) begin
      hist_d = hist_new;
      case (state_q)
        IDLE: begin
          len_d   = len_clamp;
          mode_d  = mode_i;
          fill_d  = LEN_W'(1);
          state_d = FILL;
        end
        FILL: begin
          fill_d = fill_inc;
          if (fill_inc == len_q) begin
            out_valid_d = 1'b1;
            out_d       = pal;
            if (mode_q) begin
              fill_d  = '0;
              state_d = IDLE;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          out_valid_d = 1'b1;
          out_d       = pal;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      hist_q      <= '0;
      fill_q      <= '0;
      len_q       <= '0;
      mode_q      <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
      count_sat_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
      count_sat_q <= count_sat_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_o       = out_q;
  assign count_o     = count_q;
  assign count_sat_o = count_sat_q;

endmodule
